// File: rtl/warp_pkg.sv
// Shared Warp datapath types: ALU opcode encoding, word width and the
// overflow-detecting adder used by both ADD and FMA.
package warp_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_MUL  = 3'd1,
        OP_FMA  = 3'd2,
        OP_MAX  = 3'd3,
        OP_RELU = 3'd4
    } alu_opcode_e;

    // Returns {overflow, sum}: overflow when both addends share a sign the sum lacks.
    function automatic logic [WORD_W:0] add_ovf(input logic [WORD_W-1:0] a,
                                                input logic [WORD_W-1:0] b);
        logic [WORD_W-1:0] s;
        s = a + b;
        return {(a[WORD_W-1] == b[WORD_W-1]) && (s[WORD_W-1] != a[WORD_W-1]), s};
    endfunction

endpackage

// File: rtl/alu_smul32.sv
// Combinational signed 32x32 multiplier; reports whether the 64-bit product
// fits in a signed 32-bit word and returns its low word.
module alu_smul32
    import warp_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] product_lo,
    output logic              overflow
);

    logic signed [2*WORD_W-1:0] product;

    assign product    = $signed(a) * $signed(b);
    assign product_lo = product[WORD_W-1:0];
    // Fits in 32 signed bits only if the upper 33 bits are a pure sign extension.
    assign overflow   = !((&product[2*WORD_W-1:WORD_W-1]) || ~(|product[2*WORD_W-1:WORD_W-1]));

endmodule

// File: rtl/warp_alu.sv
// Single-lane 32-bit signed ALU: combinational ADD/MUL/FMA/MAX/RELU with
// per-operation overflow, plus a registered out-of-reset ready flag.
module warp_alu
    import warp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  alu_opcode_e       opcode,
    input  logic [WORD_W-1:0] operand1,
    input  logic [WORD_W-1:0] operand2,
    input  logic [WORD_W-1:0] operand3,
    output logic [WORD_W-1:0] result,
    output logic              overflow,
    output logic              ready
);

    logic [WORD_W-1:0] mul_lo;
    logic              mul_ovf;
    logic [WORD_W:0]   add_ab;
    logic [WORD_W:0]   add_pc;

    alu_smul32 u_mul (
        .a          (operand1),
        .b          (operand2),
        .product_lo (mul_lo),
        .overflow   (mul_ovf)
    );

    assign add_ab = add_ovf(operand1, operand2);
    assign add_pc = add_ovf(mul_lo, operand3);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (opcode)
            OP_ADD: begin
                result   = add_ab[WORD_W-1:0];
                overflow = add_ab[WORD_W];
            end
            OP_MUL: begin
                result   = mul_lo;
                overflow = mul_ovf;
            end
            OP_FMA: begin
                result   = add_pc[WORD_W-1:0];
                overflow = mul_ovf | add_pc[WORD_W];
            end
            OP_MAX: begin
                // Ties return operand1.
                result = ($signed(operand2) > $signed(operand1)) ? operand2 : operand1;
            end
            OP_RELU: begin
                result = operand1[WORD_W-1] ? '0 : operand1;
            end
            default: begin
                result   = '0;
                overflow = 1'b0;
            end
        endcase
    end

    // Level flag, not a handshake: low while rst is sampled high, high ever after.
    always_ff @(posedge clk) begin
        if (rst) ready <= 1'b0;
        else     ready <= 1'b1;
    end

endmodule

// File: tb/tb_warp_alu.sv
// Directed self-checking bench for warp_alu: hand-computed vectors per
// operation, reserved opcode, unused-operand isolation and ready/reset behaviour.
module tb_warp_alu;
    import warp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    alu_opcode_e opcode;
    logic [31:0] operand1, operand2, operand3;
    logic [31:0] result;
    logic        overflow;
    logic        ready;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    warp_alu dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .operand1 (operand1),
        .operand2 (operand2),
        .operand3 (operand3),
        .result   (result),
        .overflow (overflow),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    task automatic drive(input alu_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c);
        opcode   = op;
        operand1 = a;
        operand2 = b;
        operand3 = c;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        drive(OP_ADD, 32'd2, 32'd3, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low got %b want 0", ready);
        end
        checks++;
        if (result !== 32'd5 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_result_tracks got %h/%b want 00000005/0", result, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_high got %b want 1", ready);
        end
    endtask

    task automatic test_add();
        logic [31:0] a[4], b[4], r[4];
        logic        v[4];
        a = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        b = '{32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h80000000};
        r = '{32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'h00000000};
        v = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(OP_ADD, a[i], b[i], 32'h12345678);
            checks++;
            if (result !== r[i] || overflow !== v[i]) begin
                errors++;
                $display("FAIL add[%0d] got %h/%b want %h/%b", i, result, overflow, r[i], v[i]);
            end
        end
    endtask

    task automatic test_mul();
        logic [31:0] a[4], b[4], r[4];
        logic        v[4];
        a = '{32'hFFFFFFFF, 32'h00010000, 32'h7FFFFFFF, 32'h00000005};
        b = '{32'hFFFFFFFF, 32'h00010000, 32'h00000002, 32'hFFFFFFFF};
        r = '{32'h00000001, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFB};
        v = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(OP_MUL, a[i], b[i], 32'hDEADBEEF);
            checks++;
            if (result !== r[i] || overflow !== v[i]) begin
                errors++;
                $display("FAIL mul[%0d] got %h/%b want %h/%b", i, result, overflow, r[i], v[i]);
            end
        end
    endtask

    task automatic test_fma();
        logic [31:0] a[5], b[5], c[5], r[5];
        logic        v[5];
        a = '{32'd2, 32'hFFFFFFFF, 32'h00010000, 32'h7FFFFFFF, 32'd5};
        b = '{32'd3, 32'd2,        32'h00010000, 32'd1,        32'd6};
        c = '{32'd4, 32'd5,        32'd0,        32'h7FFFFFFF, 32'hFFFFFFFF};
        r = '{32'h0000000A, 32'h00000003, 32'h00000000, 32'hFFFFFFFE, 32'h0000001D};
        v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(OP_FMA, a[i], b[i], c[i]);
            checks++;
            if (result !== r[i] || overflow !== v[i]) begin
                errors++;
                $display("FAIL fma[%0d] got %h/%b want %h/%b", i, result, overflow, r[i], v[i]);
            end
        end
    endtask

    task automatic test_max();
        logic [31:0] a[4], b[4], r[4];
        a = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd5};
        b = '{32'h00000001, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'd5};
        r = '{32'h00000001, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(OP_MAX, a[i], b[i], 32'hFFFFFFFF);
            checks++;
            if (result !== r[i] || overflow !== 1'b0) begin
                errors++;
                $display("FAIL max[%0d] got %h/%b want %h/0", i, result, overflow, r[i]);
            end
        end
    endtask

    task automatic test_relu();
        logic [31:0] a[5], r[5];
        a = '{32'h10, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h0};
        r = '{32'h10, 32'h0,        32'h0,        32'h7FFFFFFF, 32'h0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(OP_RELU, a[i], 32'h7FFFFFFF, 32'h7FFFFFFF);
            checks++;
            if (result !== r[i] || overflow !== 1'b0) begin
                errors++;
                $display("FAIL relu[%0d] got %h/%b want %h/0", i, result, overflow, r[i]);
            end
        end
    endtask

    task automatic test_reserved();
        alu_opcode_e op;
        for (int k = 5; k < 8; k++) begin
            op = alu_opcode_e'(k[2:0]);
            @(negedge clk);
            drive(op, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
            checks++;
            if (result !== 32'h0 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL reserved_op%0d got %h/%b want 00000000/0", k, result, overflow);
            end
        end
    endtask

    task automatic test_unused_operands();
        logic [31:0] junk;
        for (int i = 0; i < 4; i++) begin
            junk = $urandom_range(0, 32'hFFFF) << (i * 4);
            @(negedge clk);
            drive(OP_ADD, 32'd10, 32'd20, junk);
            checks++;
            if (result !== 32'd30 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL unused_add_c[%0d] got %h/%b want 0000001e/0", i, result, overflow);
            end
            drive(OP_RELU, 32'd7, junk, ~junk);
            checks++;
            if (result !== 32'd7 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL unused_relu_bc[%0d] got %h/%b want 00000007/0", i, result, overflow);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp;
        alu_opcode_e ops[4];
        logic [31:0] a[4], b[4], c[4], r[4];
        logic        v[4];
        ops = '{OP_MUL, OP_ADD, OP_FMA, OP_MAX};
        a   = '{32'h00000003, 32'h40000000, 32'h00000004, 32'hFFFFFFF0};
        b   = '{32'hFFFFFFFD, 32'h40000000, 32'h00000004, 32'hFFFFFFF1};
        c   = '{32'h0,        32'h0,        32'hFFFFFFF0, 32'h0};
        r   = '{32'hFFFFFFF7, 32'h80000000, 32'h00000000, 32'hFFFFFFF1};
        v   = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) exp_q.push_back({v[i], r[i]});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(ops[i], a[i], b[i], c[i]);
            exp = exp_q.pop_front();
            checks++;
            if ({overflow, result} !== exp || ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d] got %b/%h rdy %b want %b/%h rdy 1", i, overflow, result,
                         ready, exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_midstream_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(OP_MUL, 32'd7, 32'd6, 32'd0);
        @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ready got %b want 0", ready);
        end
        @(negedge clk);
        drive(OP_ADD, 32'h7FFFFFFF, 32'd1, 32'd0);
        checks++;
        if (result !== 32'h80000000 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL midreset_tracks got %h/%b want 80000000/1", result, overflow);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_release got %b want 1", ready);
        end
    endtask

    initial begin
        rst      = 1'b1;
        opcode   = OP_ADD;
        operand1 = '0;
        operand2 = '0;
        operand3 = '0;
        test_reset();
        test_add();
        test_mul();
        test_fma();
        test_max();
        test_relu();
        test_reserved();
        test_unused_operands();
        test_back_to_back();
        test_midstream_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
